// File: rtl/fpalu_pkg.sv
// Shared types and constants for the FP ALU datapaths (adder and pipelined subtractor).
package fpalu_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    // Significand plus guard, round and sticky.
    localparam int unsigned EXT_W  = SIG_W + 3;
    localparam int unsigned SUM_W  = EXT_W + 1;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC00000;
    localparam logic [FP_W-1:0] PINF = 32'h7F800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } ufloat_t;

    // Stage 1 output: aligned operands ready for the add/sub stage.
    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic             eff_sub;
        logic [EXT_W-1:0] asig;
        logic [EXT_W-1:0] bsig;
        logic             special;
        logic [FP_W-1:0]  spec_val;
    } align_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SUM_W-1:0] sig;
        logic             special;
        logic [FP_W-1:0]  spec_val;
    } stage_t;

    // Denormals flush to a signed zero; normals get the hidden bit.
    function automatic ufloat_t unpack_flush(input logic [FP_W-1:0] x);
        ufloat_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.sig  = (x[30:23] == 8'h00) ? '0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fpalu_lzc.sv
// 28-bit leading-zero counter used by the normalise stage; all-zero input counts 28.
module fpalu_lzc
    import fpalu_pkg::*;
(
    input  logic [SUM_W-1:0] in_i,
    output logic [4:0]       cnt_o
);

    always_comb begin
        cnt_o = 5'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (in_i[i]) cnt_o = 5'(SUM_W - 1 - i);
        end
    end

endmodule

// File: rtl/fpalu_sub.sv
// 3-stage pipelined single-precision subtractor (diff = a - b) with valid/ready flow control.
// FPALU_SUB_RNE_EN selects round-to-nearest-even; otherwise results are truncated.
module fpalu_sub
    import fpalu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a_input,
    input  logic [FP_W-1:0] b_input,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] diff
);

    align_t          s1_d, s1_q;
    stage_t          s2_d, s2_q;
    logic            v3_q;
    logic [FP_W-1:0] diff_d, diff_q;
    logic            advance;

    assign advance   = !v3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign diff      = diff_q;

    logic [FP_W-1:0]    b_neg;
    ufloat_t            ua, ub, big, sml;
    logic               a_nan, b_nan, a_inf, b_inf, swap;
    logic [EXP_W-1:0]   shift;
    logic [EXT_W-1:0]   sml_ext;
    logic [2*EXT_W-1:0] wide;

    always_comb begin
        b_neg   = {~b_input[31], b_input[30:0]};
        ua      = unpack_flush(a_input);
        ub      = unpack_flush(b_neg);
        a_nan   = (&a_input[30:23]) && (|a_input[22:0]);
        b_nan   = (&b_input[30:23]) && (|b_input[22:0]);
        a_inf   = (&a_input[30:23]) && !(|a_input[22:0]);
        b_inf   = (&b_input[30:23]) && !(|b_input[22:0]);
        swap    = {ub.exp, ub.sig} > {ua.exp, ua.sig};
        big     = swap ? ub : ua;
        sml     = swap ? ua : ub;
        shift   = big.exp - sml.exp;
        sml_ext = {sml.sig, 3'b000};
        // Upper half is the aligned field, lower half the shifted-out bits.
        wide    = {sml_ext, {EXT_W{1'b0}}} >> shift;

        s1_d         = '0;
        s1_d.valid   = in_valid;
        s1_d.sign    = big.sign;
        s1_d.exp     = big.exp;
        s1_d.eff_sub = big.sign ^ sml.sign;
        s1_d.asig    = {big.sig, 3'b000};
        if (shift >= 8'(EXT_W)) begin
            s1_d.bsig = {{(EXT_W-1){1'b0}}, |sml_ext};
        end else begin
            s1_d.bsig = {wide[2*EXT_W-1:EXT_W+1], wide[EXT_W] | (|wide[EXT_W-1:0])};
        end

        s1_d.spec_val = QNAN;
        if (a_nan || b_nan) begin
            s1_d.special = 1'b1;
        end else if (a_inf && b_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = (a_input[31] == b_neg[31]) ? {a_input[31], PINF[30:0]} : QNAN;
        end else if (a_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = {a_input[31], PINF[30:0]};
        end else if (b_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = {b_neg[31], PINF[30:0]};
        end
    end

    always_comb begin
        s2_d.valid    = s1_q.valid;
        s2_d.sign     = s1_q.sign;
        s2_d.exp      = s1_q.exp;
        s2_d.special  = s1_q.special;
        s2_d.spec_val = s1_q.spec_val;
        if (s1_q.eff_sub) s2_d.sig = {1'b0, s1_q.asig} - {1'b0, s1_q.bsig};
        else              s2_d.sig = {1'b0, s1_q.asig} + {1'b0, s1_q.bsig};
    end

    logic [4:0]        lz;
    logic [EXT_W-1:0]  norm;
    logic [9:0]        exp_n, exp_r;
    logic [FRAC_W-1:0] frac;
`ifdef FPALU_SUB_RNE_EN
    logic              inc;
    logic [SIG_W:0]    rsum;
`else
    logic [3:0]        unused_bits;
`endif

    fpalu_lzc u_lzc (
        .in_i  (s2_q.sig),
        .cnt_o (lz)
    );

    always_comb begin
        if (s2_q.sig[SUM_W-1]) begin
            norm  = {s2_q.sig[SUM_W-1:2], s2_q.sig[1] | s2_q.sig[0]};
            exp_n = {2'b00, s2_q.exp} + 10'd1;
        end else begin
            norm  = s2_q.sig[EXT_W-1:0] << (lz - 5'd1);
            exp_n = {2'b00, s2_q.exp} - {5'b00000, lz} + 10'd1;
        end
`ifdef FPALU_SUB_RNE_EN
        inc   = norm[2] & (norm[1] | norm[0] | norm[3]);
        rsum  = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, inc};
        frac  = rsum[SIG_W] ? rsum[SIG_W-1:1] : rsum[SIG_W-2:0];
        exp_r = exp_n + {9'b0, rsum[SIG_W]};
`else
        unused_bits = {norm[EXT_W-1], norm[2:0]};
        frac  = norm[EXT_W-2:3];
        exp_r = exp_n;
`endif
        if (s2_q.special)                 diff_d = s2_q.spec_val;
        else if (s2_q.sig == '0)          diff_d = '0;
        else if ($signed(exp_r) >= 10'sd255) diff_d = {s2_q.sign, PINF[30:0]};
        else if ($signed(exp_r) <= 10'sd0)   diff_d = '0;
        else                              diff_d = {s2_q.sign, exp_r[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            v3_q   <= 1'b0;
            diff_q <= '0;
        end else if (advance) begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            v3_q   <= s2_q.valid;
            diff_q <= diff_d;
        end
    end

endmodule
